lvl_cross_reconstructor: RTL and testbench
==========================================

Name: lvl_cross_reconstructor

Overview:
- Parametrised successor to the single-table level-crossing sample converter.
- Accepts level-crossing samples {direction, timestamp} from the SGDMA stream and tracks the current amplitude band.
- For each sample, emits a reconstructed value plus {upper,lower} band limits for `timestamp` accepted output beats.
- Adds: runtime-writable level table, midpoint/hold output modes, output backpressure, timestamp-0 handling and an overrange counter. Sits between the SGDMA reader and the reconstruction filter.

Parameters:
- DATA_W, 16, sample/level width (signed two's complement); timestamp width = DATA_W-1.
- LVLS_NUM, 20, number of levels (2..64); bands are 0..LVLS_NUM.
- LVL_RESET_VALUE, 10, band index after reset.
- IDX_W, $clog2(LVLS_NUM+1), band index width (derived).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_W  {dir (MSB, 1=up), timestamp[DATA_W-2:0]}
- in_valid  in  1  input sample valid
- in_ready  out  1  converter can accept a sample
- cfg_mode  in  1  0=midpoint, 1=hold-crossed-level; sampled at accept
- lvl_wr_en  in  1  level table write strobe
- lvl_wr_addr  in  6  level index 0..LVLS_NUM-1
- lvl_wr_data  in  DATA_W  level value
- out_value  out  DATA_W  reconstructed value
- out_limits  out  2*DATA_W  {upper, lower}
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- busy  out  1  state != IDLE
- ovr_cnt  out  16  saturating count of crossings clipped at band 0 or band LVLS_NUM

Behaviour:
- Level table:
  - Register array lvl[0..LVLS_NUM-1].
  - Reset value: lvl[i] = -2^(DATA_W-1) + (i+1)*STEP, with STEP = floor(2^DATA_W/(LVLS_NUM+1)).
  - Writes are applied only when busy=0. Writes with busy=1 or with addr >= LVLS_NUM are dropped.
  - Monotonic ordering is the software's responsibility.
- Bands:
  - Band B = [lo,hi], with lo = (B==0 ? 0x8000-equivalent MIN : lvl[B-1]) and hi = (B==LVLS_NUM ? MAX : lvl[B]).
  - Up crossing: B = min(B+1, LVLS_NUM). Down crossing: B = max(B-1, 0).
  - A clipped step leaves B unchanged and increments ovr_cnt, which saturates at 0xFFFF.
- Value:
  - Midpoint mode: (sext(lo)+sext(hi)) >>> 1, computed at DATA_W+1 bits and truncated to DATA_W.
  - Hold mode: lo after an up crossing, hi after a down crossing.
  - out_limits = {hi, lo}.
- FSM:
  - States: IDLE -> FETCH -> CALC -> EMIT -> IDLE.
  - IDLE: in_ready=1. Accept at cycle T (in_valid & in_ready); latch dir, timestamp and mode, and update B.
  - FETCH (T+1): register lo/hi.
  - CALC (T+2): register value/limits. If timestamp==0, go to IDLE with no output beats (B stays updated).
  - EMIT: from T+3, out_valid=1 and outputs stable. The beat counter decrements on each out_valid & out_ready. When the last beat is accepted, go to IDLE (out_valid=0 next cycle). With no backpressure, in_ready returns at T+3+timestamp.
  - out_valid never drops while beats remain; out_value/out_limits are held constant when out_ready=0.
- Reset (any cycle, including mid-EMIT):
  - State=IDLE, B=LVL_RESET_VALUE, table reset, ovr_cnt=0.
  - out_valid=0, out_value=0, out_limits=0, busy=0, in_ready=0 during reset, 1 in the first cycle after.
  - Any in-flight sample is discarded.
- in_data is ignored when in_ready=0.

Decomposition:
- Package lvl_cross_pkg:
  - LVL_CROSS_SAMPLE_T packed struct {dir, timestamp}, parametrised via DATA_W localparam.
  - Mode enum (MODE_MID, MODE_HOLD).
  - FSM state enum.
  - Function lvl_init(i) for reset levels.
- Sub-module lvl_table: register array with gated write port and registered 2-entry read (lo/hi) including MIN/MAX edge substitution.

Test Plan:
All scenarios use defaults (STEP=0x0C30, lvl[9]=0xF9E0, lvl[10]=0x0610, lvl[11]=0x1240, lvl[19]=0x73C0).
1. After reset, up/ts=5, mode=0, out_ready=1 -> out_valid from T+3 for 5 cycles; value=0x0C28, limits=0x1240_0610; in_ready back at T+8.
2. After reset, down/ts=5, mode=0 -> value=0xF3C8, limits=0xF9E0_EDB0. Repeat with mode=1 -> value=0xF9E0.
3. 12 up crossings from reset, ts=2 -> last band 20: value=0x79DF, limits=0x7FFF_73C0, ovr_cnt=2. Symmetric 12 downs reach band 0 with lower=0x8000.
4. up/ts=4 with out_ready toggling 1,0,0,1,... -> exactly 4 accepted beats, outputs stable while stalled, in_ready low throughout.
5. up/ts=0 -> no out_valid pulse, in_ready high again at T+3. A following up/ts=1 -> band 12 midpoint 0x1858.
6. Write lvl[10]=0x0000 while idle -> an up crossing gives limits=0x1240_0000. A write issued during EMIT is ignored. Reset asserted mid-EMIT -> out_valid=0 the next cycle and band returns to 10.

Source files
------------

// File: rtl/lvl_cross_pkg.sv
// Shared types and helpers for the level-crossing reconstructor.
//   lvl_cross_sample_t : {dir, timestamp} view of one input sample (DATA_W wide)
//   mode_e             : output value mode (midpoint / hold crossed level)
//   state_e            : converter FSM states
//   lvl_init()         : reset image of the level table
package lvl_cross_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic              dir;        // 1 = upward crossing
    logic [DATA_W-2:0] timestamp;  // number of output beats to emit
  } lvl_cross_sample_t;

  typedef enum logic {
    MODE_MID  = 1'b0,
    MODE_HOLD = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_EMIT
  } state_e;

  // Evenly spaced levels across the signed range: MIN + (idx+1)*STEP,
  // STEP = floor(2^data_w / (lvls_num+1)).
  function automatic longint lvl_init(input int idx, input int data_w, input int lvls_num);
    longint step;
    step = (longint'(1) << data_w) / longint'(lvls_num + 1);
    return -(longint'(1) << (data_w - 1)) + longint'(idx + 1) * step;
  endfunction

endpackage

// File: rtl/lvl_table.sv
// Runtime-writable level table with a registered two-entry band read.
//   clock, reset          : system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : level write port, applied only when wr_allow=1
//                           and wr_addr < LVLS_NUM
//   wr_allow              : write gate (converter idle)
//   band                  : band index 0..LVLS_NUM to read
//   lo, hi                : registered band limits; band 0 reads MIN as lo,
//                           band LVLS_NUM reads MAX as hi
module lvl_table
  import lvl_cross_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LVLS_NUM = 20,
  parameter int IDX_W    = $clog2(LVLS_NUM + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_allow,
  input  logic [IDX_W-1:0]  band,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int                AW       = $clog2(LVLS_NUM);
  localparam logic [6:0]        LVLS_N7  = 7'(LVLS_NUM);
  localparam logic [IDX_W-1:0]  BAND_MAX = IDX_W'(LVLS_NUM);
  localparam logic [DATA_W-1:0] VAL_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] VAL_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] lvl [LVLS_NUM];
  logic [IDX_W-1:0]  band_m1;
  logic              wr_ok;

  assign band_m1 = band - IDX_W'(1);
  assign wr_ok   = wr_en & wr_allow & ({1'b0, wr_addr} < LVLS_N7);

  // NOTE: the levels live in flops rather than a RAM macro because they need
  // a defined reset image; a RAM could not be cleared by reset like this.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LVLS_NUM; i++) begin
        lvl[i] <= DATA_W'(lvl_init(i, DATA_W, LVLS_NUM));
      end
      lo <= '0;
      hi <= '0;
    end else begin
      if (wr_ok) begin
        lvl[wr_addr[AW-1:0]] <= wr_data;
      end
      lo <= (band == '0)       ? VAL_MIN : lvl[band_m1[AW-1:0]];
      hi <= (band == BAND_MAX) ? VAL_MAX : lvl[band[AW-1:0]];
    end
  end

endmodule

// File: rtl/lvl_cross_reconstructor.sv
// Level-crossing sample converter: tracks the current amplitude band and, for
// each {dir, timestamp} sample, emits `timestamp` beats of a reconstructed
// value plus {upper, lower} band limits.
//   clock, reset       : system clock, synchronous active-high reset
//   in_data/valid/ready: sample stream {dir (MSB, 1=up), timestamp}
//   cfg_mode           : 0=midpoint, 1=hold crossed level (latched at accept)
//   lvl_wr_*           : level table write port (ignored while busy)
//   out_value/limits   : reconstructed value and {hi, lo}
//   out_valid/ready    : output beat handshake
//   busy               : converter is not idle
//   ovr_cnt            : saturating count of crossings clipped at band 0/LVLS_NUM
module lvl_cross_reconstructor
  import lvl_cross_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int LVLS_NUM        = 20,
  parameter int LVL_RESET_VALUE = 10,
  parameter int IDX_W           = $clog2(LVLS_NUM + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                cfg_mode,
  input  logic                lvl_wr_en,
  input  logic [5:0]          lvl_wr_addr,
  input  logic [DATA_W-1:0]   lvl_wr_data,
  output logic [DATA_W-1:0]   out_value,
  output logic [2*DATA_W-1:0] out_limits,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         ovr_cnt
);

  localparam int               TS_W     = DATA_W - 1;
  localparam logic [IDX_W-1:0] BAND_MAX = IDX_W'(LVLS_NUM);

  state_e             state;
  logic [IDX_W-1:0]   band;
  logic [IDX_W-1:0]   band_nxt;
  logic               clip;
  logic               dir_q;
  mode_e              mode_q;
  logic [TS_W-1:0]    beats;
  logic [DATA_W-1:0]  lo;
  logic [DATA_W-1:0]  hi;
  logic signed [DATA_W:0] sum;
  logic [DATA_W-1:0]  mid;
  logic               accept;

  // in_ready is decoded from state so it is already high in the first cycle
  // after reset releases, and held low while reset is asserted.
  assign in_ready = (state == ST_IDLE) & ~reset;
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid & in_ready;

  lvl_table #(
    .DATA_W   (DATA_W),
    .LVLS_NUM (LVLS_NUM),
    .IDX_W    (IDX_W)
  ) u_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (lvl_wr_en),
    .wr_addr  (lvl_wr_addr),
    .wr_data  (lvl_wr_data),
    .wr_allow (~busy),
    .band     (band),
    .lo       (lo),
    .hi       (hi)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    band_nxt = band;
    clip     = 1'b0;
    if (in_data[DATA_W-1]) begin
      if (band == BAND_MAX) clip = 1'b1;
      else                  band_nxt = band + IDX_W'(1);
    end else begin
      if (band == '0) clip = 1'b1;
      else            band_nxt = band - IDX_W'(1);
    end
  end

  // Midpoint at DATA_W+1 bits so lo+hi cannot overflow; the arithmetic shift
  // is taking the upper DATA_W bits of the sign-extended sum.
  always_comb begin
    sum = $signed({lo[DATA_W-1], lo}) + $signed({hi[DATA_W-1], hi});
    mid = sum[DATA_W:1];
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      band       <= IDX_W'(LVL_RESET_VALUE);
      dir_q      <= 1'b0;
      mode_q     <= MODE_MID;
      beats      <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_limits <= '0;
      ovr_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir_q  <= in_data[DATA_W-1];
            beats  <= in_data[TS_W-1:0];
            mode_q <= mode_e'(cfg_mode);
            band   <= band_nxt;
            if (clip && (ovr_cnt != 16'hFFFF)) ovr_cnt <= ovr_cnt + 16'd1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_CALC;  // table registers lo/hi for the new band
        ST_CALC: begin
          out_value  <= (mode_q == MODE_HOLD) ? (dir_q ? lo : hi) : mid;
          out_limits <= {hi, lo};
          if (beats == '0) begin
            state <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            beats <= beats - TS_W'(1);
            if (beats == TS_W'(1)) begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvl_cross_reconstructor.sv
// Directed self-checking bench for lvl_cross_reconstructor (default parameters).
module tb_lvl_cross_reconstructor;
  import lvl_cross_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cfg_mode;
  logic        lvl_wr_en;
  logic [5:0]  lvl_wr_addr;
  logic [15:0] lvl_wr_data;
  logic [15:0] out_value;
  logic [31:0] out_limits;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] ovr_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  bit emit_wr  = 1'b0;

  always #5 clock = ~clock;

  lvl_cross_reconstructor dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cfg_mode    (cfg_mode),
    .lvl_wr_en   (lvl_wr_en),
    .lvl_wr_addr (lvl_wr_addr),
    .lvl_wr_data (lvl_wr_data),
    .out_value   (out_value),
    .out_limits  (out_limits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .ovr_cnt     (ovr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    lvl_wr_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_limits", out_limits, 0);
    check("rst_ovr_cnt", ovr_cnt, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_ready", in_ready, 1);
  endtask

  task automatic wr_level(input logic [5:0] addr, input logic [15:0] data);
    lvl_wr_en   = 1'b1;
    lvl_wr_addr = addr;
    lvl_wr_data = data;
    @(negedge clock);
    lvl_wr_en   = 1'b0;
  endtask

  // Presents one sample in cycle T; returns at the negedge of cycle T+1.
  task automatic send_sample(input logic dir, input logic [14:0] ts, input logic mode);
    lvl_cross_sample_t s;
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("send_in_ready", in_ready, 1);
    s.dir     = dir;
    s.timestamp = ts;
    in_data   = s;
    cfg_mode  = mode;
    in_valid  = 1'b1;
    @(negedge clock);
    in_valid  = 1'b0;
  endtask

  // Called at T+1 with out_ready=1; walks T+1 .. T+3+ts.
  task automatic expect_beats(input int ts, input logic [15:0] v, input logic [31:0] l, input bit chk);
    if (chk) begin
      check("t1_out_valid", out_valid, 0);
      check("t1_busy", busy, 1);
    end
    @(negedge clock);
    if (chk) check("t2_out_valid", out_valid, 0);
    for (int i = 0; i < ts; i++) begin
      @(negedge clock);
      lvl_wr_en = emit_wr && (i == 0);
      if (chk) begin
        check("beat_valid", out_valid, 1);
        check("beat_value", out_value, v);
        check("beat_limits", out_limits, l);
        check("beat_in_ready", in_ready, 0);
      end
    end
    @(negedge clock);
    lvl_wr_en = 1'b0;
    emit_wr   = 1'b0;
    if (chk) begin
      check("done_out_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_mode = 1'b0;
    lvl_wr_en = 1'b0; lvl_wr_addr = '0; lvl_wr_data = '0; out_ready = 1'b1;

    // 1: up from band 10 -> band 11 midpoint, 5 beats.
    do_reset();
    send_sample(1'b1, 15'd5, 1'b0);
    expect_beats(5, 16'h0C28, 32'h1240_0610, 1'b1);

    // 2: down -> band 9, midpoint then hold.
    do_reset();
    send_sample(1'b0, 15'd5, 1'b0);
    expect_beats(5, 16'hF3C8, 32'hF9E0_EDB0, 1'b1);
    do_reset();
    send_sample(1'b0, 15'd5, 1'b1);
    expect_beats(5, 16'hF9E0, 32'hF9E0_EDB0, 1'b1);

    // 3: 12 ups clip twice at band 20; 12 downs clip twice at band 0.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_sample(1'b1, 15'd2, 1'b0);
      expect_beats(2, 16'h0, 32'h0, 1'b0);
    end
    send_sample(1'b1, 15'd2, 1'b0);
    expect_beats(2, 16'h79DF, 32'h7FFF_73C0, 1'b1);
    check("top_ovr_cnt", ovr_cnt, 2);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_sample(1'b0, 15'd2, 1'b0);
      expect_beats(2, 16'h0, 32'h0, 1'b0);
    end
    send_sample(1'b0, 15'd2, 1'b0);
    expect_beats(2, 16'h8618, 32'h8C30_8000, 1'b1);
    check("bottom_ovr_cnt", ovr_cnt, 2);

    // 4: backpressure, out_ready high every third cycle -> beats at 0,3,6,9.
    do_reset();
    send_sample(1'b1, 15'd4, 1'b0);
    @(negedge clock);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      out_ready = (c % 3 == 0);
      check("bp_out_valid", out_valid, (c < 10) ? 1 : 0);
      if (c < 10) begin
        check("bp_value", out_value, 16'h0C28);
        check("bp_limits", out_limits, 32'h1240_0610);
        check("bp_in_ready", in_ready, 0);
      end else begin
        check("bp_done_ready", in_ready, 1);
      end
    end
    out_ready = 1'b1;

    // 5: timestamp 0 emits nothing but moves the band; then ts=1 at band 12.
    do_reset();
    send_sample(1'b1, 15'd0, 1'b0);
    expect_beats(0, 16'h0, 32'h0, 1'b1);
    send_sample(1'b1, 15'd1, 1'b0);
    expect_beats(1, 16'h1858, 32'h1E70_1240, 1'b1);

    // 6: idle write takes effect, write during EMIT is dropped.
    do_reset();
    wr_level(6'd10, 16'h0000);
    send_sample(1'b1, 15'd2, 1'b0);
    expect_beats(2, 16'h0920, 32'h1240_0000, 1'b1);
    lvl_wr_addr = 6'd11;
    lvl_wr_data = 16'h5555;
    emit_wr     = 1'b1;
    send_sample(1'b1, 15'd3, 1'b0);
    expect_beats(3, 16'h1858, 32'h1E70_1240, 1'b1);
    send_sample(1'b0, 15'd1, 1'b1);
    expect_beats(1, 16'h1240, 32'h1240_0000, 1'b1);

    // Reset mid-EMIT, then an out-of-range write must not alias onto lvl[8].
    send_sample(1'b1, 15'd5, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_release_ready", in_ready, 1);
    wr_level(6'd40, 16'h1111);
    send_sample(1'b0, 15'd1, 1'b0);
    expect_beats(1, 16'hF3C8, 32'hF9E0_EDB0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
